riscv_mc_ctrl_hs: RTL and testbench

//  Next-generation multicycle RV32I control FSM with a req/ready memory handshake (wait states), a watchdog, sub-word store/load byte enables, full branch set, LUI/AUIPC/JAL/JALR and a trap state.

---
 rtl/riscv_mc_ctrl_hs_pkg.sv | 74 +++++++
 rtl/riscv_mc_ctrl_hs_branch_be_dec.sv | 53 +++++
 rtl/riscv_mc_ctrl_hs.sv | 249 ++++++++++++++++++++++++
 tb/tb_riscv_mc_ctrl_hs.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_ctrl_hs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mc_ctrl_hs_pkg
//  Brief    : Shared encodings for the multicycle RV32I handshake controller:
//             opcodes, state codes and datapath select encodings.
//  Revision : 1.0  initial release
// ============================================================================
package riscv_mc_ctrl_hs_pkg;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    // Controller state encoding
    localparam logic [3:0] c_st_reset   = 4'd0;
    localparam logic [3:0] c_st_fetch   = 4'd1;
    localparam logic [3:0] c_st_decode  = 4'd2;
    localparam logic [3:0] c_st_exec_r  = 4'd3;
    localparam logic [3:0] c_st_exec_i  = 4'd4;
    localparam logic [3:0] c_st_mem_adr = 4'd5;
    localparam logic [3:0] c_st_mem_rd  = 4'd6;
    localparam logic [3:0] c_st_mem_wb  = 4'd7;
    localparam logic [3:0] c_st_mem_wr  = 4'd8;
    localparam logic [3:0] c_st_alu_wb  = 4'd9;
    localparam logic [3:0] c_st_branch  = 4'd10;
    localparam logic [3:0] c_st_jal     = 4'd11;
    localparam logic [3:0] c_st_jalr    = 4'd12;
    localparam logic [3:0] c_st_lui     = 4'd13;
    localparam logic [3:0] c_st_auipc   = 4'd14;
    localparam logic [3:0] c_st_trap    = 4'd15;

    // ALU operand A select
    localparam logic [1:0] c_srca_pc    = 2'd0;
    localparam logic [1:0] c_srca_a     = 2'd1;
    localparam logic [1:0] c_srca_oldpc = 2'd2;

    // ALU operand B select
    localparam logic [1:0] c_srcb_b     = 2'd0;
    localparam logic [1:0] c_srcb_four  = 2'd1;
    localparam logic [1:0] c_srcb_imm   = 2'd2;

    // ALU operation class
    localparam logic [1:0] c_aluop_add  = 2'd0;
    localparam logic [1:0] c_aluop_sub  = 2'd1;
    localparam logic [1:0] c_aluop_func = 2'd2;

    // Register write-back source
    localparam logic [1:0] c_res_aluout = 2'd0;
    localparam logic [1:0] c_res_data   = 2'd1;
    localparam logic [1:0] c_res_pc     = 2'd2;
    localparam logic [1:0] c_res_imm    = 2'd3;

    // PC source select
    localparam logic [1:0] c_pcsrc_alures = 2'd0;
    localparam logic [1:0] c_pcsrc_aluout = 2'd1;
    localparam logic [1:0] c_pcsrc_jalr   = 2'd2;

    // Branch func3 codes
    localparam logic [2:0] c_f3_beq  = 3'b000;
    localparam logic [2:0] c_f3_bne  = 3'b001;
    localparam logic [2:0] c_f3_blt  = 3'b100;
    localparam logic [2:0] c_f3_bge  = 3'b101;
    localparam logic [2:0] c_f3_bltu = 3'b110;
    localparam logic [2:0] c_f3_bgeu = 3'b111;

endpackage
`default_nettype wire

// File: rtl/riscv_mc_ctrl_hs_branch_be_dec.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mc_ctrl_hs_branch_be_dec
//  Brief    : Combinational decode of branch-taken, data byte enables and
//             sub-word misalignment from func3, ALU flags and address bits.
//  Revision : 1.0  initial release
// ============================================================================
module riscv_mc_ctrl_hs_branch_be_dec
    import riscv_mc_ctrl_hs_pkg::*;
(
    input  logic [2:0] i_func3,
    input  logic       i_zero,
    input  logic       i_lt,
    input  logic       i_ltu,
    input  logic [1:0] i_addr_lo,
    output logic       o_taken,
    output logic       o_branch_ok,
    output logic [3:0] o_data_be,
    output logic       o_misaligned
);

    // Branch condition; func3 010/011 are not branch encodings
    always_comb begin
        o_taken     = 1'b0;
        o_branch_ok = 1'b1;
        case (i_func3)
            c_f3_beq:  o_taken = i_zero;
            c_f3_bne:  o_taken = ~i_zero;
            c_f3_blt:  o_taken = i_lt;
            c_f3_bge:  o_taken = ~i_lt;
            c_f3_bltu: o_taken = i_ltu;
            c_f3_bgeu: o_taken = ~i_ltu;
            default:   o_branch_ok = 1'b0;
        endcase
    end

    // Byte enables by access size; halfword ignores addr bit 0, word ignores both
    always_comb begin
        o_data_be    = 4'b1111;
        o_misaligned = 1'b0;
        case (i_func3[1:0])
            2'b00: o_data_be = 4'b0001 << i_addr_lo;
            2'b01: begin
                o_data_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_misaligned = i_addr_lo[0];
            end
            2'b10: o_misaligned = |i_addr_lo;
            default: o_data_be = 4'b1111;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_mc_ctrl_hs.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mc_ctrl_hs
//  Brief    : Multicycle RV32I control FSM with req/ready memory handshake,
//             memory-wait watchdog, sub-word byte enables and trap state.
//  Revision : 1.0  initial release
// ============================================================================
module riscv_mc_ctrl_hs
    import riscv_mc_ctrl_hs_pkg::*;
#(
    parameter int TIMEOUT_W     = 8,
    parameter int TIMEOUT_MAX   = 255,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic [1:0] addr_lo,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic [3:0] mem_be,
    output logic       IorD,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       illegal,
    output logic       mem_timeout
);

    // Watchdog fires on the cycle whose stall would bring the count to TIMEOUT_MAX
    localparam logic [TIMEOUT_W-1:0] c_wd_last = TIMEOUT_W'(TIMEOUT_MAX - 1);

    logic [3:0]           r_state;
    logic [3:0]           w_state_nxt;
    logic [TIMEOUT_W-1:0] r_wd;
    logic                 w_wd_expire;
    logic                 w_set_illegal;
    logic                 w_set_timeout;
    logic                 r_illegal;
    logic                 r_timeout;
    logic                 w_taken;
    logic                 w_branch_ok;
    logic [3:0]           w_data_be;
    logic                 w_misaligned;
    logic                 w_unused_func7;

    // func7 is decoded by the ALU decoder, not by this controller
    assign w_unused_func7 = ^func7;

    riscv_mc_ctrl_hs_branch_be_dec u_dec (
        .i_func3      (func3),
        .i_zero       (zero),
        .i_lt         (lt),
        .i_ltu        (ltu),
        .i_addr_lo    (addr_lo),
        .o_taken      (w_taken),
        .o_branch_ok  (w_branch_ok),
        .o_data_be    (w_data_be),
        .o_misaligned (w_misaligned)
    );

    assign w_wd_expire = mem_req && !mem_ready && (r_wd == c_wd_last);
    assign illegal     = r_illegal;
    assign mem_timeout = r_timeout;

    // State register; reset drops every request combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_reset;
        else     r_state <= w_state_nxt;
    end

    // Watchdog counts consecutive stalled request cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      r_wd <= '0;
        else if (mem_req && !mem_ready) r_wd <= r_wd + 1'b1;
        else                          r_wd <= '0;
    end

    // Sticky trap cause flags, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_illegal <= r_illegal | w_set_illegal;
            r_timeout <= r_timeout | w_set_timeout;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_be        = 4'b0000;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = c_srca_pc;
        ALUSrcB       = c_srcb_b;
        ALUOp         = c_aluop_add;
        ResultSrc     = c_res_aluout;
        PCSrc         = c_pcsrc_alures;
        PCWrite       = 1'b0;
        case (r_state)
            c_st_reset: w_state_nxt = c_st_fetch;
            c_st_fetch: begin
                mem_req = 1'b1;
                mem_be  = 4'b1111;
                ALUSrcB = c_srcb_four;
                if (mem_ready) begin
                    IRWrite     = 1'b1;
                    PCWrite     = 1'b1;
                    w_state_nxt = c_st_decode;
                end else if (w_wd_expire) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = c_st_trap;
                end
            end
            c_st_decode: begin
                ALUSrcA = c_srca_oldpc;
                ALUSrcB = c_srcb_imm;
                case (opcode)
                    c_op_r:      w_state_nxt = c_st_exec_r;
                    c_op_i:      w_state_nxt = c_st_exec_i;
                    c_op_load,
                    c_op_store:  w_state_nxt = c_st_mem_adr;
                    c_op_branch: w_state_nxt = c_st_branch;
                    c_op_jal:    w_state_nxt = c_st_jal;
                    c_op_jalr:   w_state_nxt = c_st_jalr;
                    c_op_lui:    w_state_nxt = c_st_lui;
                    c_op_auipc:  w_state_nxt = c_st_auipc;
                    default: begin
                        w_set_illegal = 1'b1;
                        w_state_nxt   = c_st_trap;
                    end
                endcase
            end
            c_st_exec_r: begin
                ALUSrcA     = c_srca_a;
                ALUSrcB     = c_srcb_b;
                ALUOp       = c_aluop_func;
                w_state_nxt = c_st_alu_wb;
            end
            c_st_exec_i: begin
                ALUSrcA     = c_srca_a;
                ALUSrcB     = c_srcb_imm;
                ALUOp       = c_aluop_func;
                w_state_nxt = c_st_alu_wb;
            end
            c_st_auipc: begin
                ALUSrcA     = c_srca_oldpc;
                ALUSrcB     = c_srcb_imm;
                w_state_nxt = c_st_alu_wb;
            end
            c_st_alu_wb: begin
                RegWrite    = 1'b1;
                ResultSrc   = c_res_aluout;
                w_state_nxt = c_st_fetch;
            end
            c_st_lui: begin
                RegWrite    = 1'b1;
                ResultSrc   = c_res_imm;
                w_state_nxt = c_st_fetch;
            end
            c_st_mem_adr: begin
                ALUSrcA = c_srca_a;
                ALUSrcB = c_srcb_imm;
                if (MISALIGN_TRAP && w_misaligned) w_state_nxt = c_st_trap;
                else if (opcode == c_op_store)     w_state_nxt = c_st_mem_wr;
                else                               w_state_nxt = c_st_mem_rd;
            end
            c_st_mem_rd: begin
                mem_req = 1'b1;
                mem_be  = w_data_be;
                IorD    = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = c_st_mem_wb;
                end else if (w_wd_expire) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = c_st_trap;
                end
            end
            c_st_mem_wb: begin
                RegWrite    = 1'b1;
                ResultSrc   = c_res_data;
                w_state_nxt = c_st_fetch;
            end
            c_st_mem_wr: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                mem_be  = w_data_be;
                IorD    = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = c_st_fetch;
                end else if (w_wd_expire) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = c_st_trap;
                end
            end
            c_st_branch: begin
                ALUSrcA = c_srca_a;
                ALUSrcB = c_srcb_b;
                ALUOp   = c_aluop_sub;
                PCSrc   = c_pcsrc_aluout;
                if (w_branch_ok) begin
                    PCWrite     = w_taken;
                    w_state_nxt = c_st_fetch;
                end else begin
                    w_set_illegal = 1'b1;
                    w_state_nxt   = c_st_trap;
                end
            end
            c_st_jal: begin
                RegWrite    = 1'b1;
                ResultSrc   = c_res_pc;
                PCSrc       = c_pcsrc_aluout;
                PCWrite     = 1'b1;
                w_state_nxt = c_st_fetch;
            end
            c_st_jalr: begin
                RegWrite    = 1'b1;
                ResultSrc   = c_res_pc;
                ALUSrcA     = c_srca_a;
                ALUSrcB     = c_srcb_imm;
                PCSrc       = c_pcsrc_jalr;
                PCWrite     = 1'b1;
                w_state_nxt = c_st_fetch;
            end
            c_st_trap: w_state_nxt = c_st_trap;
            default:   w_state_nxt = c_st_trap;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mc_ctrl_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_mc_ctrl_hs
//  Brief    : Directed self-checking bench for riscv_mc_ctrl_hs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_mc_ctrl_hs;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero, lt, ltu;
    logic [1:0] addr_lo;
    logic       mem_ready;
    logic       mem_req, mem_we, IorD, IRWrite, RegWrite, PCWrite;
    logic [3:0] mem_be;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc, PCSrc;
    logic       illegal, mem_timeout;

    int n_cmp = 0;
    int n_err = 0;

    riscv_mc_ctrl_hs dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .zero        (zero),
        .lt          (lt),
        .ltu         (ltu),
        .addr_lo     (addr_lo),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .IorD        (IorD),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .ResultSrc   (ResultSrc),
        .PCSrc       (PCSrc),
        .PCWrite     (PCWrite),
        .illegal     (illegal),
        .mem_timeout (mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3);
        opcode = op;
        func3  = f3;
    endtask

    // Hold reset across one edge, release, next edge lands in FETCH
    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic ok;
        rst = 1'b1; opcode = '0; func3 = '0; func7 = '0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; addr_lo = 2'd0; mem_ready = 1'b0;
        #2;
        chk("rst_req",      mem_req, 0);
        chk("rst_irw",      IRWrite, 0);
        chk("rst_pcw",      PCWrite, 0);
        chk("rst_regw",     RegWrite, 0);
        chk("rst_be",       mem_be, 0);
        chk("rst_illegal",  illegal, 0);
        chk("rst_timeout",  mem_timeout, 0);

        // ADD with zero wait states
        step(); rst = 1'b0;
        set_instr(7'b0110011, 3'b000); mem_ready = 1'b1;
        step(); #1;
        chk("add_f_req",  mem_req, 1);
        chk("add_f_iord", IorD, 0);
        chk("add_f_be",   mem_be, 4'hf);
        chk("add_f_irw",  IRWrite, 1);
        chk("add_f_pcw",  PCWrite, 1);
        chk("add_f_srcb", ALUSrcB, 1);
        step(); #1;
        chk("add_d_req",  mem_req, 0);
        chk("add_d_srca", ALUSrcA, 2);
        chk("add_d_srcb", ALUSrcB, 2);
        chk("add_d_pcw",  PCWrite, 0);
        step(); #1;
        chk("add_x_aluop", ALUOp, 2);
        chk("add_x_srca",  ALUSrcA, 1);
        chk("add_x_regw",  RegWrite, 0);
        step(); #1;
        chk("add_wb_regw", RegWrite, 1);
        chk("add_wb_res",  ResultSrc, 0);
        chk("add_wb_pcw",  PCWrite, 0);

        // Fetch with three wait states, then BLTU taken
        mem_ready = 1'b0;
        set_instr(7'b1100011, 3'b110); lt = 1'b0; ltu = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("ws_req",  mem_req, 1);
            chk("ws_iord", IorD, 0);
            chk("ws_be",   mem_be, 4'hf);
            chk("ws_irw",  IRWrite, 0);
        end
        step(); mem_ready = 1'b1; #1;
        chk("ws4_req", mem_req, 1);
        chk("ws4_irw", IRWrite, 1);
        step(); #1;
        step(); #1;
        chk("bltu_pcw",   PCWrite, 1);
        chk("bltu_pcsrc", PCSrc, 1);
        chk("bltu_aluop", ALUOp, 1);

        // BGE with lt=1: not taken
        step(); set_instr(7'b1100011, 3'b101); lt = 1'b1; #1;
        chk("bge_f_req", mem_req, 1);
        step(); #1;
        step(); #1;
        chk("bge_pcw",     PCWrite, 0);
        chk("bge_illegal", illegal, 0);

        // SB at addr_lo=2
        step(); set_instr(7'b0100011, 3'b000); addr_lo = 2'd2; #1;
        step(); #1;
        step(); #1;
        chk("sb_adr_req",  mem_req, 0);
        chk("sb_adr_srcb", ALUSrcB, 2);
        step(); #1;
        chk("sb_req",  mem_req, 1);
        chk("sb_we",   mem_we, 1);
        chk("sb_be",   mem_be, 4'b0100);
        chk("sb_iord", IorD, 1);

        // LH at addr_lo=2: upper halfword, five-cycle load
        step(); set_instr(7'b0000011, 3'b001); #1;
        chk("lh_f_irw", IRWrite, 1);
        step(); #1;
        step(); #1;
        step(); #1;
        chk("lh_req", mem_req, 1);
        chk("lh_we",  mem_we, 0);
        chk("lh_be",  mem_be, 4'b1100);
        step(); #1;
        chk("lh_wb_regw", RegWrite, 1);
        chk("lh_wb_res",  ResultSrc, 1);

        // JALR
        step(); set_instr(7'b1100111, 3'b000); #1;
        step(); #1;
        step(); #1;
        chk("jalr_regw",  RegWrite, 1);
        chk("jalr_res",   ResultSrc, 2);
        chk("jalr_pcsrc", PCSrc, 2);
        chk("jalr_pcw",   PCWrite, 1);
        chk("jalr_srca",  ALUSrcA, 1);

        // LUI
        step(); set_instr(7'b0110111, 3'b000); #1;
        step(); #1;
        step(); #1;
        chk("lui_regw", RegWrite, 1);
        chk("lui_res",  ResultSrc, 3);

        // SH at addr_lo=1: misaligned, trap without a request
        step(); set_instr(7'b0100011, 3'b001); addr_lo = 2'd1; #1;
        step(); #1;
        step(); #1;
        step(); #1;
        chk("sh_mis_req", mem_req, 0);
        chk("sh_mis_we",  mem_we, 0);
        step(); #1;
        chk("sh_mis_hold", mem_req, 0);
        chk("sh_mis_ill",  illegal, 0);

        // Branch func3=010 is illegal
        pulse_reset(); addr_lo = 2'd0;
        set_instr(7'b1100011, 3'b010);
        step(); #1;
        chk("rst_to_fetch", mem_req, 1);
        step(); #1;
        step(); #1;
        chk("bill_pcw", PCWrite, 0);
        step(); #1;
        chk("bill_illegal", illegal, 1);
        chk("bill_req",     mem_req, 0);

        // Watchdog: fetch never acknowledged
        pulse_reset(); mem_ready = 1'b0;
        chk("wd_rst_illegal", illegal, 0);
        ok = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            step(); #1;
            if (mem_req !== 1'b1 || mem_timeout !== 1'b0) ok = 1'b0;
        end
        chk("wd_hold_255", ok, 1);
        step(); #1;
        chk("wd_timeout", mem_timeout, 1);
        chk("wd_req_drop", mem_req, 0);
        step(); #1;
        chk("wd_trap_hold", mem_req, 0);

        // Reset during a stalled SW
        pulse_reset(); mem_ready = 1'b1;
        set_instr(7'b0100011, 3'b010);
        step(); #1;
        step(); #1;
        step(); mem_ready = 1'b0; #1;
        step(); #1;
        chk("sw_wait_req", mem_req, 1);
        chk("sw_wait_be",  mem_be, 4'hf);
        step(); #1;
        chk("sw_wait2_we", mem_we, 1);
        rst = 1'b1; #1;
        chk("midrst_req",  mem_req, 0);
        chk("midrst_we",   mem_we, 0);
        chk("midrst_be",   mem_be, 0);
        chk("midrst_regw", RegWrite, 0);
        chk("midrst_pcw",  PCWrite, 0);
        chk("midrst_to",   mem_timeout, 0);
        step();
        rst = 1'b0; mem_ready = 1'b1;
        #1;
        chk("rel_idle_req", mem_req, 0);
        step(); #1;
        chk("rel_fetch_req", mem_req, 1);
        chk("rel_fetch_irw", IRWrite, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
